// File: rtl/v850_fetch_pkg.sv
// Shared V850 fetch/decode types: halfword type, fetch FSM states and the
// instruction length rule used by both the fetch queue and the decoder.
package v850_fetch_pkg;

  typedef logic [15:0] halfword_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2
  } fetch_state_e;

  // Format V+ opcodes (opcode field [10:5] = 11xxxx) carry a second halfword.
  function automatic logic is_len32(input halfword_t hw);
    return hw[10:9] == 2'b11;
  endfunction

endpackage

// File: rtl/ifq_hw_buffer.sv
// Circular halfword buffer: writes a tail slice of one fetch word per cycle,
// peeks the two oldest halfwords and pops 0, 1 or 2 of them.
module ifq_hw_buffer
  import v850_fetch_pkg::*;
#(
  parameter int MEM_W  = 64,
  parameter int QDEPTH = 8,
  localparam int HW_PER_W = MEM_W / 16,
  localparam int OFF_W    = $clog2(HW_PER_W),
  localparam int PTR_W    = $clog2(QDEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [OFF_W-1:0] i_wr_start,
  input  logic [MEM_W-1:0] i_wr_data,
  input  logic [1:0]       i_pop,
  output logic [15:0]      o_hw0,
  output logic [15:0]      o_hw1,
  output logic [CNT_W-1:0] o_count
);

  halfword_t        r_mem [QDEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_wr_num;
  logic [PTR_W-1:0] w_rd_ptr1;

  assign w_wr_num  = i_wr_en ? (CNT_W'(HW_PER_W) - CNT_W'(i_wr_start)) : '0;
  assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (i_wr_en && !i_flush) begin
      for (int k = 0; k < HW_PER_W; k++) begin
        if (k >= int'(i_wr_start))
          r_mem[r_wr_ptr + PTR_W'(k - int'(i_wr_start))] <= i_wr_data[16*k +: 16];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
      r_wr_ptr <= r_wr_ptr + w_wr_num[PTR_W-1:0];
      r_count  <= r_count + w_wr_num - CNT_W'(i_pop);
    end
  end

  assign o_hw0   = r_mem[r_rd_ptr];
  assign o_hw1   = r_mem[w_rd_ptr1];
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// V850 instruction fetch unit: issues aligned fetches, buffers halfwords and
// hands whole 16/32-bit instructions with their PC to decode.
module ifetch_queue
  import v850_fetch_pkg::*;
#(
  parameter int             MEM_W    = 64,
  parameter int             QDEPTH   = 8,
  parameter int             PC_W     = 25,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  output logic             mem_req_o,
  output logic [PC_W-1:0]  mem_addr_o,
  input  logic             mem_ack_i,
  input  logic             mem_valid_i,
  input  logic [MEM_W-1:0] mem_data_i,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [31:0]      instruction_o,
  output logic             inst_len32_o,
  output logic [PC_W-1:0]  pc_o
);

  localparam int HW_PER_W = MEM_W / 16;
  localparam int OFF_W    = $clog2(HW_PER_W);
  localparam int CNT_W    = $clog2(QDEPTH) + 1;

  fetch_state_e     r_state;
  fetch_state_e     w_next_state;
  logic             r_stale;
  logic             r_run;
  logic [PC_W-1:0]  r_fetch_pc;
  logic [PC_W-1:0]  r_head_pc;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_free;
  logic             w_room;
  logic             w_resp;
  logic             w_enq;
  logic [1:0]       w_pop;
  logic [15:0]      w_hw0;
  logic [15:0]      w_hw1;
  logic             w_len32;
  logic [PC_W-1:0]  w_fetch_aligned;

  ifq_hw_buffer #(
    .MEM_W  (MEM_W),
    .QDEPTH (QDEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (redirect_i),
    .i_wr_en    (w_enq),
    .i_wr_start (r_fetch_pc[OFF_W-1:0]),
    .i_wr_data  (mem_data_i),
    .i_pop      (w_pop),
    .o_hw0      (w_hw0),
    .o_hw1      (w_hw1),
    .o_count    (w_count)
  );

  assign w_fetch_aligned = {r_fetch_pc[PC_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_free          = CNT_W'(QDEPTH) - w_count;
  assign w_room          = w_free >= CNT_W'(HW_PER_W);

  // r_run keeps the request low while reset is held and for the first cycle after.
  assign mem_req_o  = !redirect_i &&
                      ((r_state == FS_IDLE && r_run && w_room) || r_state == FS_REQ);
  assign mem_addr_o = w_fetch_aligned;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_resp       = 1'b0;
    if (mem_req_o) begin
      if (mem_ack_i) begin
        w_resp       = mem_valid_i;
        w_next_state = mem_valid_i ? FS_IDLE : FS_WAIT;
      end else begin
        w_next_state = FS_REQ;
      end
    end else if (r_state == FS_REQ) begin
      w_next_state = FS_IDLE;
    end
    if (r_state == FS_WAIT && mem_valid_i) begin
      w_resp       = 1'b1;
      w_next_state = FS_IDLE;
    end
  end

  assign w_enq = w_resp && !r_stale && !redirect_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FS_IDLE;
      r_stale <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_run   <= 1'b1;
      // A withdrawn (unacked) request needs no stale marker; only WAIT has data in flight.
      if (redirect_i && r_state == FS_WAIT && !mem_valid_i)
        r_stale <= 1'b1;
      else if (w_resp)
        r_stale <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_head_pc  <= RESET_PC;
    end else if (redirect_i) begin
      r_fetch_pc <= redirect_pc_i;
      r_head_pc  <= redirect_pc_i;
    end else begin
      if (w_enq)
        r_fetch_pc <= w_fetch_aligned + PC_W'(HW_PER_W);
      r_head_pc <= r_head_pc + PC_W'(w_pop);
    end
  end

  assign w_len32       = is_len32(w_hw0);
  assign inst_valid_o  = (w_count >= CNT_W'(1) && !w_len32) ||
                         (w_count >= CNT_W'(2) &&  w_len32);
  assign inst_len32_o  = (w_count != '0) && w_len32;
  assign instruction_o = !inst_valid_o ? 32'h0 :
                         w_len32       ? {w_hw1, w_hw0} : {16'h0, w_hw0};
  assign w_pop         = (inst_valid_o && inst_ready_i) ? (w_len32 ? 2'd2 : 2'd1) : 2'd0;
  assign pc_o          = r_head_pc;

endmodule
